// File: rtl/serial_add_sub_pkg.sv
// serial_add_sub_pkg: shared state encoding and mode constants for the serial adder/subtractor
package serial_add_sub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/ripple_digit.sv
// ripple_digit: combinational DIGIT-bit ripple adder built from chained half-adder pairs
module ripple_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);
  logic [DIGIT:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    logic h, g1, g2;
    assign h       = x[i] ^ y[i];
    assign g1      = x[i] & y[i];
    assign s[i]    = h ^ c[i];
    assign g2      = h & c[i];
    assign c[i+1]  = g1 | g2;
  end
  assign cout     = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];
endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub: multi-cycle add/subtract, DIGIT bits per cycle LSB first, with carry/borrow and overflow
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || WIDTH % DIGIT != 0) begin : g_chk
    $error("serial_add_sub: WIDTH must be >= 2 and a multiple of DIGIT");
  end
  state_t                 state;
  logic [WIDTH-1:0]       ra, rb, rr;
  logic                   c, m;
  logic [CW-1:0]          cnt;
  logic [DIGIT-1:0]       s;
  logic                   cout, cmsb, last;
  logic [WIDTH+DIGIT-1:0] rr_cat;
  ripple_digit #(.DIGIT(DIGIT)) u_rd (
    .x(ra[DIGIT-1:0]), .y(rb[DIGIT-1:0]), .cin(c), .s(s), .cout(cout), .c_msb_in(cmsb)
  );
  // new sum digit enters at the MSB end so the first digit lands at bit 0 after N shifts
  assign rr_cat = {s, rr};
  assign last   = cnt == CW'(N - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      ra        <= '0;
      rb        <= '0;
      rr        <= '0;
      c         <= 1'b0;
      m         <= 1'b0;
      cnt       <= '0;
    end else if (state == RUN) begin
      ra  <= ra >> DIGIT;
      rb  <= rb >> DIGIT;
      rr  <= rr_cat[WIDTH+DIGIT-1:DIGIT];
      c   <= cout;
      cnt <= cnt + CW'(1);
      if (last) begin
        state     <= DONE;
        busy      <= 1'b0;
        done      <= 1'b1;
        result    <= rr_cat[WIDTH+DIGIT-1:DIGIT];
        carry_out <= cout ^ m;
        overflow  <= cmsb ^ cout;
      end
    end else begin
      done  <= 1'b0;
      state <= IDLE;
      if (start) begin
        state <= RUN;
        busy  <= 1'b1;
        ra    <= a;
        rb    <= mode == MODE_ADD ? b : ~b;
        c     <= mode;
        m     <= mode;
        cnt   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: random and directed checks of two serial_add_sub instances against an arithmetic model
module tb_serial_add_sub;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;

  logic start8 = 0, mode8 = 0, busy8, done8, co8, ov8;
  logic [7:0] a8 = 0, b8 = 0, res8;
  logic start16 = 0, mode16 = 0, busy16, done16, co16, ov16;
  logic [15:0] a16 = 0, b16 = 0, res16;

  serial_add_sub #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .carry_out(co8), .overflow(ov8)
  );
  serial_add_sub #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(res16), .carry_out(co16), .overflow(ov16)
  );

  int checks = 0, errors = 0, lat = 0, bsy = 0;
  bit chk_en = 0;

  task automatic check(input string nm, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // returns {overflow, carry/borrow, result} straight from integer arithmetic
  function automatic logic [17:0] ref_op(input int w, input bit sub, input int x, input int y);
    int  md = 1 << w;
    int  full = sub ? x - y : x + y;
    int  r = ((full % md) + md) % md;
    bit  sa = bit'((x >> (w - 1)) & 1);
    bit  sb = bit'((y >> (w - 1)) & 1);
    bit  sr = bit'((r >> (w - 1)) & 1);
    bit  c = sub ? (x < y) : (full >= md);
    bit  v = sub ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
    return {v, c, 16'(r)};
  endfunction

  bit m8_busy, m8_done, m16_busy, m16_done;
  int m8_left, m16_left;
  logic [17:0] m8_out = '0, m8_pend = '0, m16_out = '0, m16_pend = '0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m8_busy <= 0; m8_done <= 0; m8_out <= '0; m8_left <= 0;
    end else if (m8_busy) begin
      m8_left <= m8_left - 1;
      if (m8_left == 1) begin m8_busy <= 0; m8_done <= 1; m8_out <= m8_pend; end
    end else begin
      m8_done <= 0;
      if (start8) begin m8_busy <= 1; m8_left <= 8; m8_pend <= ref_op(8, mode8, int'(a8), int'(b8)); end
    end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m16_busy <= 0; m16_done <= 0; m16_out <= '0; m16_left <= 0;
    end else if (m16_busy) begin
      m16_left <= m16_left - 1;
      if (m16_left == 1) begin m16_busy <= 0; m16_done <= 1; m16_out <= m16_pend; end
    end else begin
      m16_done <= 0;
      if (start16) begin m16_busy <= 1; m16_left <= 4; m16_pend <= ref_op(16, mode16, int'(a16), int'(b16)); end
    end

  always @(negedge clk)
    if (chk_en) begin
      check("busy8", 18'(busy8), 18'(m8_busy));
      check("done8", 18'(done8), 18'(m8_done));
      check("flags8_result8", {ov8, co8, 8'h00, res8}, {m8_out[17:16], 8'h00, m8_out[7:0]});
      check("busy16", 18'(busy16), 18'(m16_busy));
      check("done16", 18'(done16), 18'(m16_done));
      check("flags16_result16", {ov16, co16, res16}, m16_out);
    end

  task automatic wait_done(input bit big, input bit junk);
    int n = 1, nb = 0;
    while (!(big ? done16 : done8) && n < 40) begin
      nb += int'(big ? busy16 : busy8);
      if (junk && n == 3) begin start8 = 1; mode8 = 1; a8 = 8'hAA; b8 = 8'h55; end
      else start8 = 0;
      @(negedge clk);
      n++;
    end
    lat = n;
    bsy = nb;
  endtask

  task automatic go(input bit big, input bit md, input int x, input int y, input bit junk);
    @(negedge clk);
    if (big) begin start16 = 1; mode16 = md; a16 = 16'(x); b16 = 16'(y); end
    else begin start8 = 1; mode8 = md; a8 = 8'(x); b8 = 8'(y); end
    @(negedge clk);
    start8 = 0;
    start16 = 0;
    wait_done(big, junk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk_en = 1;
    check("reset_outputs8", {busy8, done8, co8, ov8, res8}, 12'h000);
    check("reset_outputs16", {busy16, done16, co16, ov16}, 4'h0);
    check("model_add_ff_01", ref_op(8, 0, 'hFF, 1), 18'h10000);
    check("model_sub_05_07", ref_op(8, 1, 5, 7), 18'h100FE);
    check("model_sub_80_01", ref_op(8, 1, 'h80, 1), 18'h2007F);
    check("model_add_7f_01", ref_op(8, 0, 'h7F, 1), 18'h20080);

    go(0, 0, 'hFF, 'h01, 0);
    check("add_ff_01", {ov8, co8, res8}, 10'b01_0000_0000);
    check("latency8", 18'(lat), 18'd9);
    check("busy_cycles8", 18'(bsy), 18'd8);
    go(0, 0, 'h7F, 'h01, 0);
    check("add_7f_01", {ov8, co8, res8}, 10'b10_1000_0000);
    go(0, 1, 'h05, 'h07, 0);
    check("sub_05_07", {ov8, co8, res8}, 10'b01_1111_1110);
    go(0, 1, 'h80, 'h01, 0);
    check("sub_80_01", {ov8, co8, res8}, 10'b10_0111_1111);
    go(0, 1, 'h05, 'h00, 0);
    check("sub_b_zero", {ov8, co8, res8}, 10'b00_0000_0101);

    go(0, 0, 'h12, 'h34, 1);
    check("start_ignored_while_busy", 18'(res8), 18'h46);
    check("latency_with_ignored_start", 18'(lat), 18'd9);

    go(0, 0, 3, 4, 0);
    check("b2b_first", 18'(res8), 18'd7);
    start8 = 1; mode8 = 0; a8 = 8'd10; b8 = 8'd20;
    @(negedge clk);
    start8 = 0;
    check("b2b_no_idle_gap", 18'(busy8), 18'd1);
    wait_done(0, 0);
    check("b2b_second", 18'(res8), 18'd30);
    check("b2b_latency", 18'(lat), 18'd9);

    @(negedge clk);
    start8 = 1; mode8 = 0; a8 = 8'h12; b8 = 8'h34;
    @(negedge clk);
    start8 = 0;
    repeat (3) @(negedge clk);
    #1 rst_n = 0;
    #1 check("reset_mid_run", {busy8, done8, res8}, 10'h000);
    repeat (2) @(negedge clk);
    rst_n = 1;
    go(0, 0, 1, 2, 0);
    check("after_reset_op", {ov8, co8, res8}, 10'd3);
    check("after_reset_latency", 18'(lat), 18'd9);

    go(1, 0, 'hFFFF, 'h0001, 0);
    check("add16_ffff_0001", {ov16, co16, res16}, 18'h10000);
    check("latency16", 18'(lat), 18'd5);
    check("busy_cycles16", 18'(bsy), 18'd4);

    for (int i = 0; i < 1000; i++) go(1, 1'($urandom_range(0, 1)), int'($urandom), int'($urandom), 0);
    for (int i = 0; i < 200; i++) go(0, 1'($urandom_range(0, 1)), int'($urandom), int'($urandom), 0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
Parametrised multi-cycle adder/subtractor built around a DIGIT-bit ripple slice. It consumes WIDTH-bit operands DIGIT bits per cycle, LSB first, using a start/busy/done handshake. It supersedes the single-bit combinational half adder in datapaths where area matters more than latency. It also reports carry/borrow and signed overflow.

Parameters:
WIDTH, 8, operand/result width in bits; must be at least 2 and an integer multiple of DIGIT.
DIGIT, 1, bits processed per cycle; 1 <= DIGIT <= WIDTH.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request; sampled only when busy=0.
mode  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
a  input  WIDTH  operand A; sampled with start.
b  input  WIDTH  operand B; sampled with start.
busy  output  1  high while an operation is in progress.
done  output  1  single-cycle pulse; result and flags are valid from this cycle onward.
result  output  WIDTH  sum or difference, modulo 2^WIDTH.
carry_out  output  1  add: carry out of the MSB; subtract: borrow (1 when a<b unsigned).
overflow  output  1  signed (two's complement) overflow.

Behaviour:
- One clock. Reset is asynchronous and active-low. No synchronous reset.
- Reset values: state=IDLE, busy=0, done=0, result=0, carry_out=0, overflow=0, internal shift registers and counter=0.
- Reset mid-operation aborts immediately. No done pulse is issued; outputs return to their reset values.
- States: IDLE, RUN, DONE.
  - IDLE: if start, latch a, latch b (stored as ~b when mode=1), set the carry flop to mode, latch mode, clear the counter, go to RUN. Otherwise stay in IDLE.
  - RUN: busy=1. Each cycle:
    - Add the low DIGIT bits of the A and B shift registers plus the carry flop.
    - Shift the A and B registers right by DIGIT.
    - Shift the DIGIT sum bits into the result register from the MSB end.
    - Update the carry flop and increment the counter.
    - After WIDTH/DIGIT cycles, go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0. Then go to IDLE. If start is high in DONE, a new operation is accepted exactly as in IDLE (go to RUN), allowing back-to-back operations.
- start while busy=1 is ignored. It is not queued, and operands are not re-sampled.
- Latency: start accepted at edge N gives done high in the cycle after edge N+WIDTH/DIGIT, i.e. WIDTH/DIGIT+1 cycles after acceptance.
- Throughput: one operation per WIDTH/DIGIT+1 cycles.
- result, carry_out and overflow hold their values from DONE until the next accepted start. They do not change during RUN.
- Flags are registered at the final RUN cycle:
  - carry_out = final carry XOR latched mode.
  - overflow = carry into the MSB XOR carry out of the MSB. The carry into the MSB comes from the final slice's internal carry at bit DIGIT-1.
- Arithmetic is modulo 2^WIDTH. Subtraction is a + ~b + 1. b=0 in subtract mode therefore gives carry 1 and borrow 0.

Decomposition:
- Package serial_add_sub_pkg: state enum (IDLE, RUN, DONE), mode constants MODE_ADD=1'b0 and MODE_SUB=1'b1.
- The WIDTH/DIGIT constraint is checked by an elaboration-time assertion.
- One sub-module, ripple_digit: combinational DIGIT-bit ripple adder.
  - Inputs: x, y, cin.
  - Outputs: s, cout, and c_msb_in (carry into its top bit).
  - Built from chained half-adder pairs.

Test Plan:
- WIDTH=8, DIGIT=1, add 8'hFF + 8'h01 -> result=8'h00, carry_out=1, overflow=0. busy high for 8 cycles; done pulses once, 9 cycles after start.
- Add 8'h7F + 8'h01 -> result=8'h80, carry_out=0, overflow=1.
- Subtract 8'h05 - 8'h07 -> result=8'hFE, carry_out(borrow)=1, overflow=0. Subtract 8'h80 - 8'h01 -> result=8'h7F, borrow=0, overflow=1.
- Pulse start with different operands 3 cycles into RUN -> ignored; result matches the first operands. start held during DONE -> second operation begins with no IDLE gap.
- Assert rst_n=0 mid-RUN (cycle 4) -> busy, done and result are 0 immediately. No done pulse is issued; the next start completes normally.
- WIDTH=16, DIGIT=4, add 16'hFFFF + 16'h0001 -> result=16'h0000, carry_out=1. done 5 cycles after start. Also run 1000 randomized add/subtract operations checked against a reference model.
